// File: rtl/rf_pkg.sv
// Register-file constants and types. The same package is shared with the
// register file, so the arbiter's default widths match the file's widths.
package rf_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 5;
    localparam int NUM_REGS    = 2 ** INDEX_WIDTH;
    localparam int ZERO_REG    = 0;

    typedef logic [INDEX_WIDTH-1:0] reg_index_t;
    typedef logic [DATA_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter. It stores the index of the last requester that
// completed a handshake and grants the first active request found by searching
// upward from the requester after that one. The grant is combinational and
// one-hot. It is all zero while reset is high, or when nothing is requesting.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic          found;
    int unsigned   cand;

    // Round-robin search from last_grant+1, wrapping modulo N.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop.
        // Without the defaults a path through the loop could leave a signal
        // unassigned, and the tool would then infer a latch.
        grant  = '0;
        winner = last_grant;
        found  = 1'b0;
        cand   = 0;
        for (int off = 1; off <= N; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && !reset && req[cand]) begin
                found  = 1'b1;
                winner = IW'(cand);
            end
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    // Move the round-robin pointer only when the granted request was taken.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples values from before the edge. A blocking assignment
        // here would let the read order inside the block change the result.
        if (reset) begin
            last_grant <= IW'(N - 1);
        end else if (advance && found) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between NUM_REQ writeback
// requesters. Accepted requests pass through a one-stage output register.
// Writes to x0 are accepted but not performed. The block also publishes a
// one-hot pending_mask for the hazard unit and a saturating count of the
// cycles that valid requesters spent losing arbitration.
module rf_write_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = rf_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH = rf_pkg::INDEX_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [INDEX_WIDTH-1:0]        rf_write_index,
    output logic [DATA_WIDTH-1:0]         rf_write_data,
    output logic                          rf_write_enable,
    output logic [2**INDEX_WIDTH-1:0]     pending_mask,
    output logic [CNT_WIDTH-1:0]          stall_count
);

    import rf_pkg::*;

    // Wide enough to hold a count of 0..NUM_REQ valid requesters.
    localparam int VCW = $clog2(NUM_REQ + 1);
    // One spare bit so the stall adder can detect overflow.
    localparam int SW  = CNT_WIDTH + 1;

    logic [NUM_REQ-1:0]     grant;
    logic                   handshake;
    logic [INDEX_WIDTH-1:0] win_index;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [VCW-1:0]         valid_count;
    logic [VCW-1:0]         losers;
    logic [SW-1:0]          stall_sum;
    logic [CNT_WIDTH-1:0]   stall_next;

    // The arbiter masks its grant during reset, so no handshake can happen
    // while reset is high, even if requesters keep valid asserted.
    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .advance(handshake),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    // Select the winner's index and data. The grant is one-hot, so at most
    // one slice is chosen.
    always_comb begin
        win_index = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_index = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                win_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output register: load on a handshake, drop x0 writes, idle otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_write_index  <= '0;
            rf_write_data   <= '0;
        end else if (handshake) begin
            rf_write_index  <= win_index;
            rf_write_data   <= win_data;
            rf_write_enable <= (win_index != INDEX_WIDTH'(ZERO_REG));
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    // Decode the register being written into a one-hot hazard mask.
    always_comb begin
        pending_mask = '0;
        if (rf_write_enable) begin
            pending_mask[rf_write_index] = 1'b1;
        end
    end

    // Count the valid requesters that did not win this cycle.
    always_comb begin
        valid_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_count = valid_count + VCW'(req_valid[i]);
        end
        losers    = valid_count - VCW'(handshake);
        stall_sum = {1'b0, stall_count} + SW'(losers);
        if (stall_sum[CNT_WIDTH]) begin
            stall_next = '1;
        end else begin
            stall_next = stall_sum[CNT_WIDTH-1:0];
        end
    end

    // The stall counter saturates instead of wrapping and is cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else begin
            stall_count <= stall_next;
        end
    end

endmodule
